// File: rtl/fcn_if.sv
// -----------------------------------------------------------------------------
// fcn_if : load/control/result bundle for the fcn classifier head.
//
// Purpose
//   Groups the bulk-load strobes and arrays, the start request and the
//   result (done pulse + saturated logit) so the block exposes a single bus
//   port next to its scalar clk/rst.
//
// Signals (direction seen from the master, i.e. the feeding logic)
//   in_vec_wr     out  latch in_vec_array into the block
//   in_vec_array  out  s8 [0:IN1_N-1]          input vector
//   fc1_w_wr_all  out  latch fc1_w_array
//   fc1_w_array   out  s8 [0:OUT1_M-1][0:IN1_N-1]  FC1 weights [neuron][input]
//   fc2_w_wr_all  out  latch fc2_w_array
//   fc2_w_array   out  s8 [0:OUT1_M-1]          FC2 weights
//   start         out  begin a computation (only honoured while idle)
//   done          in   one-cycle pulse, fc2_logit valid
//   fc2_logit     in   s24 saturated FC2 result, held until the next done
// -----------------------------------------------------------------------------
interface fcn_if #(
    parameter int IN1_N  = 132,
    parameter int OUT1_M = 10
);
    logic                in_vec_wr;
    logic signed [7:0]   in_vec_array [0:IN1_N-1];
    logic                fc1_w_wr_all;
    logic signed [7:0]   fc1_w_array  [0:OUT1_M-1][0:IN1_N-1];
    logic                fc2_w_wr_all;
    logic signed [7:0]   fc2_w_array  [0:OUT1_M-1];
    logic                start;
    logic                done;
    logic signed [23:0]  fc2_logit;

    // Feeding side: drives loads and start, observes the result.
    modport master (
        output in_vec_wr,
        output in_vec_array,
        output fc1_w_wr_all,
        output fc1_w_array,
        output fc2_w_wr_all,
        output fc2_w_array,
        output start,
        input  done,
        input  fc2_logit
    );

    // Classifier side: consumes loads and start, produces the result.
    modport slave (
        input  in_vec_wr,
        input  in_vec_array,
        input  fc1_w_wr_all,
        input  fc1_w_array,
        input  fc2_w_wr_all,
        input  fc2_w_array,
        input  start,
        output done,
        output fc2_logit
    );
endinterface

// File: rtl/fcn.sv
// -----------------------------------------------------------------------------
// fcn : two-layer fully-connected classifier head.
//
// Purpose
//   FC1 maps IN1_N int8 inputs onto OUT1_M neurons (one input element per
//   cycle, all neurons multiplied in parallel), applies ReLU, then FC2 folds
//   the OUT1_M activations into one logit (one activation per cycle). The
//   40-bit FC2 accumulator is saturated to 24 bits on the way out.
//   Inputs and weights are latched in bulk while idle and persist across runs.
//
// Ports
//   clk   in  single clock, everything on posedge
//   rst   in  synchronous, active-high reset; aborts any run in progress
//   bus   fcn_if.slave  load strobes/arrays, start, done, fc2_logit
//
// Timing
//   done rises IN1_N + OUT1_M + 2 rising edges after the edge that samples
//   start: IN1_N FC1 edges, one RELU edge, OUT1_M FC2 edges, one DONE edge.
//
// Note: one shared index counter sized for IN1_N serves both layers, so
//   IN1_N must be at least OUT1_M.
// -----------------------------------------------------------------------------
module fcn #(
    parameter int IN1_N  = 132,
    parameter int OUT1_M = 10
) (
    input  logic  clk,
    input  logic  rst,
    fcn_if.slave  bus
);

    localparam int IDX_W  = (IN1_N  > 1) ? $clog2(IN1_N)  : 1;
    localparam int IDX2_W = (OUT1_M > 1) ? $clog2(OUT1_M) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST1 = IDX_W'(IN1_N - 1);
    localparam logic [IDX_W-1:0] IDX_LAST2 = IDX_W'(OUT1_M - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FC1  = 3'd1,
        S_RELU = 3'd2,
        S_FC2  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Clamp the wide FC2 sum into the signed 24-bit output range.
    function automatic logic signed [23:0] sat24(input logic signed [39:0] v);
        if (v > 40'sd8388607) begin
            return 24'sh7FFFFF;
        end else if (v < -40'sd8388608) begin
            return 24'sh800000;
        end else begin
            return v[23:0];
        end
    endfunction

    // ---------------------------------------------------------------- state
    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;

    logic signed [7:0]   in_q  [0:IN1_N-1];
    logic signed [7:0]   w1_q  [0:OUT1_M-1][0:IN1_N-1];
    logic signed [7:0]   w2_q  [0:OUT1_M-1];

    logic signed [23:0]  acc1_q [0:OUT1_M-1];
    logic signed [23:0]  fc1_out_relu [0:OUT1_M-1];
    logic signed [39:0]  acc2_q;

    logic                done_q;
    logic signed [23:0]  fc2_logit_q;

    // ------------------------------------------------------ next-state math
    logic signed [15:0]  prod1_d [0:OUT1_M-1];
    logic signed [23:0]  acc1_d  [0:OUT1_M-1];
    logic signed [23:0]  relu_d  [0:OUT1_M-1];
    logic signed [39:0]  prod2_d;
    logic signed [39:0]  acc2_d;
    logic [IDX2_W-1:0]   idx2_s;

    // FC2 walks only OUT1_M entries, so it uses the low bits of the index.
    assign idx2_s = idx_q[IDX2_W-1:0];

    // FC1 MAC for every neuron at the current input index, plus ReLU candidates.
    always_comb begin
        for (int n = 0; n < OUT1_M; n++) begin
            prod1_d[n] = 16'(in_q[idx_q]) * 16'(w1_q[n][idx_q]);
            acc1_d[n]  = acc1_q[n] + 24'(prod1_d[n]);
            if (acc1_q[n] < 24'sd0) begin
                relu_d[n] = 24'sd0;
            end else begin
                relu_d[n] = acc1_q[n];
            end
        end
    end

    // FC2 MAC at the current activation index; widened first so nothing wraps.
    always_comb begin
        prod2_d = 40'(fc1_out_relu[idx2_s]) * 40'(w2_q[idx2_s]);
        acc2_d  = acc2_q + prod2_d;
    end

    // Sequencer: loads, accumulation, ReLU, saturation and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc2_q      <= 40'sd0;
            done_q      <= 1'b0;
            fc2_logit_q <= 24'sd0;
            for (int i = 0; i < IN1_N; i++) begin
                in_q[i] <= 8'sd0;
            end
            for (int n = 0; n < OUT1_M; n++) begin
                w2_q[n]         <= 8'sd0;
                acc1_q[n]       <= 24'sd0;
                fc1_out_relu[n] <= 24'sd0;
                for (int i = 0; i < IN1_N; i++) begin
                    w1_q[n][i] <= 8'sd0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // Bulk loads are honoured only here; several may coincide.
                    if (bus.in_vec_wr) begin
                        in_q <= bus.in_vec_array;
                    end
                    if (bus.fc1_w_wr_all) begin
                        w1_q <= bus.fc1_w_array;
                    end
                    if (bus.fc2_w_wr_all) begin
                        w2_q <= bus.fc2_w_array;
                    end
                    if (bus.start) begin
                        state_q <= S_FC1;
                        idx_q   <= '0;
                        acc2_q  <= 40'sd0;
                        for (int n = 0; n < OUT1_M; n++) begin
                            acc1_q[n] <= 24'sd0;
                        end
                    end
                end

                S_FC1: begin
                    done_q <= 1'b0;
                    acc1_q <= acc1_d;
                    if (idx_q == IDX_LAST1) begin
                        state_q <= S_RELU;
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end

                S_RELU: begin
                    done_q       <= 1'b0;
                    fc1_out_relu <= relu_d;
                    idx_q        <= '0;
                    state_q      <= S_FC2;
                end

                S_FC2: begin
                    done_q <= 1'b0;
                    acc2_q <= acc2_d;
                    if (idx_q == IDX_LAST2) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end

                S_DONE: begin
                    fc2_logit_q <= sat24(acc2_q);
                    done_q      <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    // Unreachable encodings recover to idle without a pulse.
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.fc2_logit = fc2_logit_q;

endmodule

// File: tb/tb_fcn.sv
// -----------------------------------------------------------------------------
// tb_fcn : directed self-checking bench for the fcn classifier head.
// Expected values are hand-derived:
//   in[i]=(i%8)-3 sums to 58 over 132 entries, so with w1[n][*]=n+1 each
//   neuron is 58*(n+1) and with w2=1 the logit is 58*55 = 3190.
//   127*127*132 = 2129028 per neuron; times 127*10 overflows +2^23-1, and
//   times -128*10 underflows -2^23.
// -----------------------------------------------------------------------------
module tb_fcn;

    localparam int IN1_N  = 132;
    localparam int OUT1_M = 10;
    localparam int LAT    = IN1_N + OUT1_M + 2;
    localparam int BOUND  = 400;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    fcn_if #(.IN1_N(IN1_N), .OUT1_M(OUT1_M)) bus ();

    fcn #(.IN1_N(IN1_N), .OUT1_M(OUT1_M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int mode);
        for (int i = 0; i < IN1_N; i++) begin
            if (mode == 0) bus.in_vec_array[i] = 8'((i % 8) - 3);
            else           bus.in_vec_array[i] = 8'sd127;
        end
    endtask

    task automatic set_w1(input int mode);
        for (int n = 0; n < OUT1_M; n++) begin
            for (int i = 0; i < IN1_N; i++) begin
                if (mode == 0)      bus.fc1_w_array[n][i] = 8'(n + 1);
                else if (mode == 1) bus.fc1_w_array[n][i] = 8'(-(n + 1));
                else                bus.fc1_w_array[n][i] = 8'sd127;
            end
        end
    endtask

    task automatic set_w2(input int v);
        for (int n = 0; n < OUT1_M; n++) begin
            bus.fc2_w_array[n] = 8'(v);
        end
    endtask

    // One-cycle load pulse; called #1 after a posedge.
    task automatic load(input logic a, input logic b, input logic c);
        bus.in_vec_wr    = a;
        bus.fc1_w_wr_all = b;
        bus.fc2_w_wr_all = c;
        @(posedge clk); #1;
        bus.in_vec_wr    = 1'b0;
        bus.fc1_w_wr_all = 1'b0;
        bus.fc2_w_wr_all = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done === 1'b1) break;
        end
    endtask

    // Pulse start, wait for done, then confirm the pulse lasts one cycle.
    task automatic run(input string tag, input int exp_logit);
        int lat;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_logit"}, bus.fc2_logit, exp_logit);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, bus.done, 1'b0);
    endtask

    initial begin
        int lat;
        int extra;
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.in_vec_wr = 1'b0;
        bus.fc1_w_wr_all = 1'b0;
        bus.fc2_w_wr_all = 1'b0;
        bus.start = 1'b0;
        set_in(0); set_w1(0); set_w2(1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_done", bus.done, 1'b0);
        chk("rst_logit", bus.fc2_logit, 0);
        chk("rst_relu0", dut.fc1_out_relu[0], 0);

        // Basic pattern
        load(1'b1, 1'b1, 1'b1);
        run("basic", 3190);
        chk("basic_relu0", dut.fc1_out_relu[0], 58);
        chk("basic_relu9", dut.fc1_out_relu[9], 580);

        // ReLU clamp with negative weights
        set_w1(1);
        load(1'b0, 1'b1, 1'b0);
        run("relu_clamp", 0);
        chk("clamp_relu9", dut.fc1_out_relu[9], 0);

        // Positive saturation
        set_in(1); set_w1(2); set_w2(127);
        load(1'b1, 1'b1, 1'b1);
        run("sat_pos", 8388607);
        chk("sat_relu0", dut.fc1_out_relu[0], 2129028);

        // Negative saturation
        set_w2(-128);
        load(1'b0, 1'b0, 1'b1);
        run("sat_neg", -8388608);

        // Load and start while busy are ignored
        set_in(0); set_w1(0); set_w2(1);
        load(1'b1, 1'b1, 1'b1);
        set_w1(1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 20) begin
                bus.fc1_w_wr_all = 1'b1;
                bus.start = 1'b1;
            end else begin
                bus.fc1_w_wr_all = 1'b0;
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) break;
        end
        bus.fc1_w_wr_all = 1'b0;
        bus.start = 1'b0;
        chk("busy_latency", lat, LAT);
        chk("busy_logit", bus.fc2_logit, 3190);
        extra = 0;
        for (int k = 0; k < 160; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        chk("busy_single_done", extra, 0);
        run("busy_weights_kept", 3190);

        // Reset during FC2 aborts the run
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 136; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_logit", bus.fc2_logit, 0);
        chk("abort_relu3", dut.fc1_out_relu[3], 0);
        extra = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        chk("abort_no_done", extra, 0);
        set_w1(0);
        load(1'b1, 1'b1, 1'b1);
        run("after_abort", 3190);

        // Back-to-back runs with start held high; w2 reloaded in the idle gap
        bus.start = 1'b1;
        @(posedge clk); #1;
        wait_done(lat);
        chk("b2b1_latency", lat, LAT);
        chk("b2b1_logit", bus.fc2_logit, 3190);
        set_w2(2);
        bus.fc2_w_wr_all = 1'b1;
        @(posedge clk); #1;
        bus.fc2_w_wr_all = 1'b0;
        wait_done(lat);
        bus.start = 1'b0;
        chk("b2b2_latency", lat, LAT);
        chk("b2b2_logit", bus.fc2_logit, 6380);
        extra = 0;
        for (int k = 0; k < 160; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        chk("b2b_stopped", extra, 0);
        chk("b2b_logit_held", bus.fc2_logit, 6380);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
